rib_rr_arbiter: RTL and testbench
=================================

# rib_rr_arbiter

Round-robin bus arbiter for the RIB interconnect. It shares the single slave-side path among up to NUM_M masters: core data, core fetch, JTAG and UART debug. Each grant is registered and lasts until the owner drops its request, or until a bounded hold time expires while other masters are waiting. It also produces the pipeline hold flag consumed by the core.

## Interface
Parameters:
- NUM_M, 4, number of masters; index 0..NUM_M-1.
- MAX_HOLD, 8, maximum consecutive grant cycles under contention; legal range 1..255.
- CORE_MASK, 4'b0011, masters belonging to the core; used for hold_flag_o.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, reset; synchronous, active-high.
- req_i, input, NUM_M, per-master request level; held high for as long as the master needs the bus.
- lock_i, input, NUM_M, per-master lock; while the owner's bit is high, forced rotation is suppressed.
- gnt_o, output, NUM_M, one-hot registered grant; all zero when idle.
- gnt_valid_o, output, 1, high when gnt_o is non-zero.
- gnt_idx_o, output, clog2(NUM_M), index of the current owner; holds the last owner while idle.
- hold_flag_o, output, 1, combinational; equals |(req_i & CORE_MASK & ~gnt_o).

## Operation
- Reset values: state IDLE; gnt_o=0; gnt_valid_o=0; gnt_idx_o=0; rotate pointer ptr=0; hold counter cnt=0. hold_flag_o follows req_i & CORE_MASK.
- Round-robin pick: the first set bit of req_i, searching ptr, ptr+1, …, wrapping modulo NUM_M.
  - In GRANT, the search excludes the current owner unless no other master requests.
- IDLE state:
  - No request: stay in IDLE.
  - Any request: go to GRANT. Owner = pick; gnt_o = onehot(owner); cnt=0.
- GRANT state, owner k:
  - req_i[k]=0 and no other request: go to IDLE. gnt_o=0. ptr=k+1.
  - req_i[k]=0 and another request: hand off directly to the pick with no idle bubble. ptr=k+1, cnt=0.
  - req_i[k]=1, cnt==MAX_HOLD-1, lock_i[k]=0, and another request: forced rotation to the pick. ptr=k+1, cnt=0.
  - Otherwise: keep k. cnt increments, saturating at MAX_HOLD-1.
- The owner's lock_i bit blocks forced rotation indefinitely. It does not keep the grant once the owner's req_i drops.
- lock_i bits of non-owners are ignored.
- ptr arithmetic is modulo NUM_M; k=NUM_M-1 wraps ptr to 0.
- cnt width is clog2(MAX_HOLD+1). With MAX_HOLD=1, ownership rotates every cycle under contention.
- Exactly one gnt_o bit is ever set. gnt_o changes only on clock edges.

## Timing
- Request to grant: 1 cycle. req_i sampled high at edge N gives gnt_o asserted after edge N.
- Handoff: the old owner's grant drops and the new owner's grant rises on the same edge. There is no dead cycle.
- Release: the owner drops req at cycle N, and its gnt drops after edge N.
- Under full contention a master waits at most (NUM_M-1)*MAX_HOLD cycles, provided no lock is held.
- rst high at any edge, including mid-grant: all outputs return to reset values after that edge. The next grant comes no earlier than 1 cycle after rst falls.
- Simultaneous owner release and new requests are resolved in the same edge. The pointer advances before the pick, so the releasing master is lowest priority.
- hold_flag_o has zero latency from req_i. It deasserts in the cycle the core master's grant becomes visible.

## Test plan
- Single request: req_i=0001 from reset → gnt_o=0001 one cycle later. Drop req → gnt_o=0000 one cycle later; gnt_idx_o stays 0.
- Contention rotation (MAX_HOLD=8): req_i=1111 held → owners 0,1,2,3,0, each for exactly 8 cycles, with direct handoffs and no idle gaps.
- Early release: owner 0 drops req at cnt=2 while req_i=0110 → gnt_o=0010 next cycle; afterwards ptr=1.
- Lock: owner 2 with lock_i=0100 and req_i=1111 for 20 cycles → gnt_o stays 0100 for all 20 cycles. Clear lock → rotation to master 3 within 1 cycle, since cnt is saturated.
- Hold flag: master 3 owns the bus and master 0 raises req → hold_flag_o=1 in the same cycle, and stays 1 until gnt_o=0001.
- Reset mid-grant: rst=1 during owner 1 with req_i=1111 → gnt_o=0000, gnt_valid_o=0 after the edge. After rst falls, the first grant goes to master 0 (ptr=0).

Source files
------------

// File: rtl/rib_rr_arbiter.sv
// Round-robin arbiter for the RIB interconnect: registered one-hot grant,
// bounded hold under contention, per-owner lock, and a core pipeline hold flag.
module rib_rr_arbiter #(
    parameter int               NUM_M     = 4,
    parameter int               MAX_HOLD  = 8,
    parameter logic [NUM_M-1:0] CORE_MASK = 4'b0011,
    localparam int              IDX_W     = (NUM_M > 1) ? $clog2(NUM_M) : 1,
    localparam int              CNT_W     = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_M-1:0] req_i,
    input  logic [NUM_M-1:0] lock_i,
    output logic [NUM_M-1:0] gnt_o,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             hold_flag_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           r_state,  w_state_nxt;
    logic [NUM_M-1:0] r_gnt,    w_gnt_nxt;
    logic [IDX_W-1:0] r_idx,    w_idx_nxt;
    logic [IDX_W-1:0] r_ptr,    w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;

    logic [NUM_M-1:0] w_others;
    logic             w_others_any;
    logic             w_cnt_sat;
    logic [IDX_W-1:0] w_owner_inc;
    logic [IDX_W-1:0] w_pick_idle;
    logic [IDX_W-1:0] w_pick_grant;

    // First requester found searching start, start+1, ... modulo NUM_M.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_M-1:0] reqs,
                                                 input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               j;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            j = (int'(start) + i) % NUM_M;
            if (!found && reqs[j]) begin
                sel   = IDX_W'(j);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_others     = req_i & ~(NUM_M'(1) << r_idx);
    assign w_others_any = |w_others;
    assign w_cnt_sat    = (r_cnt == CNT_W'(MAX_HOLD - 1));
    assign w_owner_inc  = IDX_W'((int'(r_idx) + 1) % NUM_M);
    assign w_pick_idle  = rr_pick(req_i, r_ptr);
    // Pointer moves past the outgoing owner before the pick, so it ranks last.
    assign w_pick_grant = rr_pick(w_others, w_owner_inc);

    // NOTE: every next-state variable gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (|req_i) begin
                    w_state_nxt = ST_GRANT;
                    w_idx_nxt   = w_pick_idle;
                    w_gnt_nxt   = NUM_M'(1) << w_pick_idle;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (!req_i[r_idx] || (w_cnt_sat && !lock_i[r_idx] && w_others_any)) begin
                    w_ptr_nxt = w_owner_inc;
                    w_cnt_nxt = '0;
                    if (w_others_any) begin
                        w_idx_nxt = w_pick_grant;
                        w_gnt_nxt = NUM_M'(1) << w_pick_grant;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else if (!w_cnt_sat) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_valid_o = |r_gnt;
    assign gnt_idx_o   = r_idx;
    assign hold_flag_o = |(req_i & CORE_MASK & ~r_gnt);

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Self-checking bench for rib_rr_arbiter: directed scenarios plus random traffic,
// compared against a cycle-level ownership/tenure model.
module tb_rib_rr_arbiter;

    localparam int               NUM_M     = 4;
    localparam int               MAX_HOLD  = 8;
    localparam logic [NUM_M-1:0] CORE_MASK = 4'b0011;

    logic             clk;
    logic             rst;
    logic [NUM_M-1:0] req_i;
    logic [NUM_M-1:0] lock_i;
    logic [NUM_M-1:0] gnt_o;
    logic             gnt_valid_o;
    logic [1:0]       gnt_idx_o;
    logic             hold_flag_o;

    rib_rr_arbiter #(
        .NUM_M    (NUM_M),
        .MAX_HOLD (MAX_HOLD),
        .CORE_MASK(CORE_MASK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .lock_i     (lock_i),
        .gnt_o      (gnt_o),
        .gnt_valid_o(gnt_valid_o),
        .gnt_idx_o  (gnt_idx_o),
        .hold_flag_o(hold_flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: owner (-1 when idle), rotate pointer, cycles held so far.
    int m_owner  = -1;
    int m_ptr    = 0;
    int m_tenure = 0;
    int m_last   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_from(input logic [NUM_M-1:0] reqs, input int start);
        for (int i = 0; i < NUM_M; i++) begin
            if (reqs[(start + i) % NUM_M]) return (start + i) % NUM_M;
        end
        return -1;
    endfunction

    function automatic logic [NUM_M-1:0] exp_gnt();
        return (m_owner < 0) ? '0 : NUM_M'(1) << m_owner;
    endfunction

    task automatic model_edge(input logic r, input logic [NUM_M-1:0] rq, input logic [NUM_M-1:0] lk);
        logic [NUM_M-1:0] others;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_tenure = 0; m_last = 0;
        end else if (m_owner < 0) begin
            if (rq != 0) begin
                m_owner = first_from(rq, m_ptr); m_tenure = 1; m_last = m_owner;
            end
        end else begin
            others = rq & ~(NUM_M'(1) << m_owner);
            if (!rq[m_owner] || (m_tenure >= MAX_HOLD && !lk[m_owner] && others != 0)) begin
                m_ptr = (m_owner + 1) % NUM_M;
                if (others != 0) begin
                    m_owner = first_from(others, m_ptr); m_tenure = 1; m_last = m_owner;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_tenure++;
            end
        end
    endtask

    // One clock: drive inputs, check the combinational flag, clock, check registered outputs.
    task automatic step(input logic r, input logic [NUM_M-1:0] rq, input logic [NUM_M-1:0] lk);
        rst = r; req_i = rq; lock_i = lk;
        #1;
        check("hold_flag", 32'(hold_flag_o), 32'(|(rq & CORE_MASK & ~exp_gnt())));
        @(posedge clk);
        model_edge(r, rq, lk);
        #1;
        check("gnt", 32'(gnt_o), 32'(exp_gnt()));
        check("gnt_valid", 32'(gnt_valid_o), 32'(m_owner >= 0));
        check("gnt_idx", 32'(gnt_idx_o), 32'(m_last));
    endtask

    initial begin
        logic [NUM_M-1:0] rq;
        logic [NUM_M-1:0] lk;
        int               run;
        rst = 1'b1; req_i = '0; lock_i = '0;
        @(posedge clk); #1;

        // Reset state
        step(1'b1, 4'b0000, 4'b0000);
        check("reset_gnt", 32'(gnt_o), 32'h0);
        check("reset_idx", 32'(gnt_idx_o), 32'h0);

        // Single request, then release
        step(1'b0, 4'b0001, 4'b0000);
        check("single_gnt", 32'(gnt_o), 32'h1);
        step(1'b0, 4'b0000, 4'b0000);
        check("single_release", 32'(gnt_o), 32'h0);
        check("single_idx_kept", 32'(gnt_idx_o), 32'h0);

        // Full contention from reset: owners 0,1,2,3,0 each for MAX_HOLD cycles
        step(1'b1, 4'b0000, 4'b0000);
        for (int c = 0; c < 5 * MAX_HOLD; c++) begin
            step(1'b0, 4'b1111, 4'b0000);
            check("rotation_owner", 32'(gnt_o), 32'(1 << ((c / MAX_HOLD) % NUM_M)));
        end

        // Early release by owner 0 at cnt=2 while 1 and 2 wait
        step(1'b1, 4'b0000, 4'b0000);
        for (int c = 0; c < 3; c++) step(1'b0, 4'b0111, 4'b0000);
        step(1'b0, 4'b0110, 4'b0000);
        check("early_release", 32'(gnt_o), 32'b0010);

        // Lock held by owner 2 suppresses rotation; clearing it rotates at once
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b0100, 4'b0000);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 4'b1111, 4'b0100);
            check("lock_keep", 32'(gnt_o), 32'b0100);
        end
        step(1'b0, 4'b1111, 4'b0000);
        check("lock_cleared", 32'(gnt_o), 32'b1000);

        // Hold flag while master 3 owns and core master 0 waits
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b1000, 4'b0000);
        req_i = 4'b1001; #1;
        check("hold_flag_raise", 32'(hold_flag_o), 32'h1);
        for (int c = 0; c < MAX_HOLD + 2; c++) step(1'b0, 4'b1001, 4'b0000);
        check("hold_flag_owner0", 32'(gnt_o), 32'b0001);

        // Reset during owner 1 with full contention
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b0010, 4'b0000);
        step(1'b0, 4'b1111, 4'b0000);
        step(1'b1, 4'b1111, 4'b0000);
        check("midrst_gnt", 32'(gnt_o), 32'h0);
        check("midrst_valid", 32'(gnt_valid_o), 32'h0);
        step(1'b0, 4'b1111, 4'b0000);
        check("midrst_first", 32'(gnt_o), 32'b0001);

        // Random traffic with sticky requests, occasional locks and resets
        rq = '0; lk = '0; run = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) rq = NUM_M'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) lk = ($urandom_range(0, 2) == 0) ? NUM_M'($urandom_range(0, 15)) : '0;
            step(($urandom_range(0, 79) == 0), rq, lk);
            run++;
        end
        check("random_steps", 32'(run), 32'd600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
